// File: rtl/mdu_seq_if.sv
// mdu_seq_if: start/busy/done handshake and HI/LO result bus between the
// EX stage (master) and the iterative multiply/divide unit (slave).
interface mdu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide unit for the MIPS EX stage.
// op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV. One result bit per CALC cycle,
// then one FIX cycle for sign correction and the HI/LO write.
// Optional macro MDU_EARLY_OUT_EN: multiplies leave CALC as soon as the
// remaining multiplier bits are all zero (divide timing is unaffected).
module mdu_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  mdu_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [WIDTH-1:0]     a_raw_q, a_raw_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem;

  // Next-state logic: accept a request, iterate one bit per cycle, then
  // sign-correct and publish the result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mb_d    = mb_q;
    a_raw_d = a_raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;

    a_mag     = (bus.op[0] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag     = (bus.op[0] && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    rem_shift = {acc_q[WIDTH-1:0], mc_q[WIDTH-1]};
    rem_sub   = rem_shift[WIDTH-1:0] - mb_q;
    prod      = q_neg_q ? -acc_q : acc_q;
    quo       = q_neg_q ? -mc_q[WIDTH-1:0] : mc_q[WIDTH-1:0];
    rem       = r_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          op_d    = bus.op;
          a_raw_d = bus.a;
          mb_d    = b_mag;
          acc_d   = '0;
          mc_d    = {{WIDTH{1'b0}}, a_mag};
          cnt_d   = '0;
          q_neg_d = bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          r_neg_d = bus.op[0] & bus.a[WIDTH-1];
          dz_d    = 1'b0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (!op_q[1]) begin
          if (mb_q[0]) acc_d = acc_q + mc_q;
          mc_d = mc_q << 1;
          mb_d = mb_q >> 1;
        end else if (rem_shift >= {1'b0, mb_q}) begin
          acc_d = {{WIDTH{1'b0}}, rem_sub};
          mc_d  = {mc_q[2*WIDTH-1:WIDTH], mc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {{WIDTH{1'b0}}, rem_shift[WIDTH-1:0]};
          mc_d  = {mc_q[2*WIDTH-1:WIDTH], mc_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = FIX;
          cnt_d   = '0;
        end else if (EARLY_OUT && !op_q[1] && (mb_q >> 1) == '0) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        if (!op_q[1]) begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end else if (mb_q == '0) begin
          hi_d = a_raw_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      mc_q    <= '0;
      mb_q    <= '0;
      a_raw_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mb_q    <= mb_d;
      a_raw_q <= a_raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: self-checking bench for mdu_seq, directed plus randomized
// operations compared against an arithmetic reference model.
module tb_mdu_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
  } vec_t;

  // Reference: plain integer arithmetic and the documented latency rule.
  function automatic void model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] hi, output logic [15:0] lo,
                                output logic dz, output int lat);
    int sa, sb, q, r;
    longint up;
    logic [31:0] p;
    logic [15:0] mag;
    sa = int'($signed(a));
    sb = int'($signed(b));
    dz = 1'b0;
    lat = 18;
    p = '0;
    case (op)
      2'd0: begin up = longint'({16'b0, a}) * longint'({16'b0, b}); p = up[31:0]; end
      2'd1: begin q = sa * sb; p = q; end
      default: begin
        if (b == 16'd0) begin
          dz = 1'b1;
          p = {a, 16'hFFFF};
        end else if (op == 2'd2) begin
          q = int'({16'b0, a}) / int'({16'b0, b});
          r = int'({16'b0, a}) % int'({16'b0, b});
          p = {r[15:0], q[15:0]};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[15:0], q[15:0]};
        end
      end
    endcase
    hi = p[31:16];
    lo = p[15:0];
`ifdef MDU_EARLY_OUT_EN
    if (!op[1]) begin
      mag = (op[0] && b[15]) ? 16'(-b) : b;
      lat = 3;
      for (int i = 0; i < 16; i++) if (mag[i]) lat = i + 3;
    end
`endif
  endfunction

  // Issue one op at the current negedge; return at the negedge where done is
  // seen (or after a 40-cycle bound). cyc counts cycles after the start edge.
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int cyc, output bit busy_ok,
                       output logic [15:0] hi, output logic [15:0] lo, output logic dz);
    bus.start = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op = 2'($urandom);
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    cyc = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    hi = bus.hi;
    lo = bus.lo;
    dz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op = 2'd0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.hi !== 16'h0 || bus.lo !== 16'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: busy/done/dz=%b%b%b hi=%h lo=%h, required 000 0000 0000",
               bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    vec_t vecs[10];
    logic [15:0] hi, lo, ehi, elo;
    logic dz, edz;
    int cyc, lat;
    bit busy_ok;
    vecs = '{'{2'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0},
             '{2'd1, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0},
             '{2'd1, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0},
             '{2'd3, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0},
             '{2'd3, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0},
             '{2'd2, 16'h0064, 16'h0000, 16'h0064, 16'hFFFF, 1'b1},
             '{2'd0, 16'h1234, 16'h0003, 16'h0000, 16'h369C, 1'b0},
             '{2'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0},
             '{2'd3, 16'h0064, 16'h0000, 16'h0064, 16'hFFFF, 1'b1},
             '{2'd2, 16'hFFFF, 16'h0007, 16'h0001, 16'h2492, 1'b0}};
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b, ehi, elo, edz, lat);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, busy_ok, hi, lo, dz);
      n_checks++;
      if (cyc !== lat) begin
        n_fail++;
        $display("[TB] FAIL directed_latency[%0d]: done at N+%0d, required N+%0d", i, cyc, lat);
      end
      n_checks++;
      if (!busy_ok || bus.busy !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL directed_busy[%0d]: busy window wrong (ok=%0d busy_at_done=%b), required 1 then 0",
                 i, busy_ok, bus.busy);
      end
      n_checks++;
      if (hi !== vecs[i].hi || lo !== vecs[i].lo || dz !== vecs[i].dz) begin
        n_fail++;
        $display("[TB] FAIL directed_result[%0d]: hi=%h lo=%h dz=%b, required hi=%h lo=%h dz=%b",
                 i, hi, lo, dz, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      end
      @(negedge clk);
      n_checks++;
      if (bus.done !== 1'b0 || bus.hi !== vecs[i].hi || bus.lo !== vecs[i].lo) begin
        n_fail++;
        $display("[TB] FAIL directed_pulse[%0d]: done=%b hi=%h lo=%h one cycle later, required 0 %h %h",
                 i, bus.done, bus.hi, bus.lo, vecs[i].hi, vecs[i].lo);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, hi, lo, ehi, elo;
    logic [1:0] op;
    logic dz, edz;
    int cyc, lat;
    bit busy_ok;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: b = 16'h0;
        1: a = 16'h8000;
        2: b = 16'($urandom_range(0, 15));
        3: b = 16'hFFFF;
        default: ;
      endcase
      model(op, a, b, ehi, elo, edz, lat);
      do_op(op, a, b, cyc, busy_ok, hi, lo, dz);
      n_checks++;
      if (cyc !== lat || hi !== ehi || lo !== elo || dz !== edz) begin
        n_fail++;
        $display("[TB] FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d hi=%h lo=%h dz=%b, required lat=%0d hi=%h lo=%h dz=%b",
                 i, op, a, b, cyc, hi, lo, dz, lat, ehi, elo, edz);
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] hi, lo, ehi, elo;
    logic dz, edz;
    int cyc, lat;
    bit busy_ok;
    do_op(2'd1, 16'hFF00, 16'h0123, cyc, busy_ok, hi, lo, dz);
    model(2'd1, 16'hFF00, 16'h0123, ehi, elo, edz, lat);
    n_checks++;
    if (hi !== ehi || lo !== elo) begin
      n_fail++;
      $display("[TB] FAIL b2b_first: hi=%h lo=%h, required %h %h", hi, lo, ehi, elo);
    end
    do_op(2'd2, 16'hBEEF, 16'h0013, cyc, busy_ok, hi, lo, dz);
    model(2'd2, 16'hBEEF, 16'h0013, ehi, elo, edz, lat);
    n_checks++;
    if (cyc !== lat || !busy_ok || hi !== ehi || lo !== elo || dz !== edz) begin
      n_fail++;
      $display("[TB] FAIL b2b_second: lat=%0d busy_ok=%0d hi=%h lo=%h dz=%b, required lat=%0d 1 %h %h %b",
               cyc, busy_ok, hi, lo, dz, lat, ehi, elo, edz);
    end
    @(negedge clk);
  endtask

  task automatic test_dz_clear();
    logic [15:0] hi, lo;
    logic dz;
    int cyc;
    bit busy_ok;
    do_op(2'd2, 16'h0064, 16'h0000, cyc, busy_ok, hi, lo, dz);
    n_checks++;
    if (dz !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL dz_set: div_by_zero=%b, required 1", dz);
    end
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 16'd5;
    bus.b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.div_by_zero !== 1'b0 || bus.busy !== 1'b1 || bus.hi !== 16'h0064 || bus.lo !== 16'hFFFF) begin
      n_fail++;
      $display("[TB] FAIL dz_clear: dz=%b busy=%b hi=%h lo=%h at N+1, required 0 1 0064 ffff",
               bus.div_by_zero, bus.busy, bus.hi, bus.lo);
    end
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.lo !== 16'd25 || bus.hi !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL dz_next_result: done=%b hi=%h lo=%h, required 1 0000 0019", bus.done, bus.hi, bus.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    logic [15:0] ehi, elo;
    logic edz;
    int cyc, lat, pulse_at;
    model(2'd0, 16'd2, 16'd3, ehi, elo, edz, lat);
    pulse_at = (lat >= 6) ? 4 : 2;
    bus.start = 1'b1;
    bus.op = 2'd0;
    bus.a = 16'd2;
    bus.b = 16'd3;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < 40) begin
      if (cyc == pulse_at) begin
        bus.start = 1'b1;
        bus.op = 2'd3;
        bus.a = 16'd99;
        bus.b = 16'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    n_checks++;
    if (cyc !== lat || bus.hi !== 16'd0 || bus.lo !== 16'd6 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL busy_ignore: lat=%0d hi=%h lo=%h dz=%b, required lat=%0d 0000 0006 0",
               cyc, bus.hi, bus.lo, bus.div_by_zero, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.start = 1'b1;
    bus.op = 2'd3;
    bus.a = 16'd1000;
    bus.b = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 16'h0 || bus.lo !== 16'h0 || bus.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: busy=%b done=%b hi=%h lo=%h dz=%b, required all zero",
               bus.busy, bus.done, bus.hi, bus.lo, bus.div_by_zero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_discard: %0d cycles with busy/done after reset, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dz_clear();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative 16-bit multiply/divide unit for the pipelined MIPS EX stage.
- The EX stage issues MULT/MULTU/DIV/DIVU through a start/busy/done handshake, and this block returns results in HI/LO.
- It handles the multi-cycle ops that the combinational ALU does not.
- HI/LO outputs stay valid until the next accepted start.

Parameters:
- WIDTH, 16, operand width; HI/LO are WIDTH each.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when the unit is idle (state IDLE or DONE).
- op  input  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- a  input  WIDTH  multiplicand / dividend.
- b  input  WIDTH  multiplier / divisor.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results valid.
- hi  output  WIDTH  product[31:16] or remainder.
- lo  output  WIDTH  product[15:0] or quotient.
- div_by_zero  output  1  set with done when a divide had b==0; held until next accepted start.

Behaviour:
- Reset, asynchronous and effective immediately, including mid-operation:
  - state=IDLE, busy=0, done=0.
  - hi=0, lo=0, div_by_zero=0, counter=0.
  - The in-flight op is discarded.
- States: IDLE, CALC, FIX, DONE.
  - busy = (state==CALC or FIX).
  - done = (state==DONE).
- IDLE/DONE, start=1 at edge N:
  - Latch op.
  - Latch |a| and |b| (magnitudes for signed ops, raw for unsigned).
  - Latch the result-sign flags.
  - Clear div_by_zero; go to CALC.
  - hi/lo keep their old values until FIX completes.
- IDLE/DONE, start=0: DONE falls back to IDLE; IDLE stays in IDLE.
- CALC, one bit per cycle, counter 0..15:
  - Multiply: radix-2 shift-add on the 32-bit accumulator, LSB-first over |b|.
  - Divide: restoring shift-subtract on the remainder/quotient pair, MSB-first.
  - After count 15, go to FIX.
  - CALC lasts exactly 16 cycles (N+1..N+16).
- FIX, cycle N+17:
  - Apply sign correction; write hi/lo; go to DONE.
  - done is high in cycle N+18. Latency is start-edge to done = 18 cycles, fixed for all ops.
- start while busy is ignored; no queueing, no effect on the in-flight op.
- Signed multiply: negate the 32-bit magnitude product iff the operand signs differ.
  - -32768 * -32768 = 0x4000_0000.
- Signed divide:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - -32768 / -1 gives lo=0x8000, hi=0x0000, no flag.
- Divide by zero (b==0, op 10 or 11):
  - Same 18-cycle timing.
  - hi=a (raw), lo=0xFFFF, div_by_zero=1 when done asserts.
- Unsigned ops never negate. All arithmetic is modulo 2^32 on the combined {hi,lo}.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - Multiply ops leave CALC at the first edge where the remaining shifted multiplier is zero (or count==15).
  - k = max(1, index of the highest set bit of |b| + 1) CALC cycles.
  - FIX is at N+1+k and done at N+2+k.
  - b=0 gives done at N+3.
  - Divide timing is unchanged.
- Undefined: fixed 16 CALC cycles for every op; done at N+18.

Test Plan:
- MULTU a=0xFFFF b=0xFFFF, start at N -> busy N+1..N+17, done pulse only at N+18, hi=0xFFFE lo=0x0001.
- MULT a=0xFFFD(-3) b=0x0005 -> hi=0xFFFF lo=0xFFF1 (-15).
- MULT a=0x8000 b=0x8000 -> hi=0x4000 lo=0x0000.
- DIV a=0xFFF9(-7) b=0x0002 -> lo=0xFFFD (-3), hi=0xFFFF (-1).
- DIV a=0x8000 b=0xFFFF -> lo=0x8000, hi=0x0000, div_by_zero=0.
- DIVU a=0x0064 b=0x0000 -> done at N+18, div_by_zero=1, hi=0x0064 lo=0xFFFF.
- Next accepted start clears div_by_zero at N+1.
- Start MULTU 2*3 at N; pulse start with a different op at N+4 -> ignored, result hi=0 lo=6 at N+18.
- Separate run: rst_n low at N+5 -> busy=0, hi=lo=0 immediately, no done pulse afterwards.
- MULTU a=0x1234 b=0x0003 -> hi=0x0000 lo=0x369C.
  - With MDU_EARLY_OUT_EN: done at N+4.
  - Without MDU_EARLY_OUT_EN: done at N+18.
- With MDU_EARLY_OUT_EN, MULTU b=0 -> done at N+3, result 0.
